// File: rtl/vdp_color_mixer.sv
// ============================================================================
// vdp_color_mixer : background/sprite priority, backdrop, left-column mask,
//                   blanking and Game Gear CRAM lookup to registered 4:4:4 RGB.
// Revision 1.0
// ============================================================================
`default_nettype none

module vdp_color_mixer #(
  parameter int H_ACTIVE = 256,
  parameter int V_ACTIVE = 192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [5:0] bg_color,
  input  logic       bg_priority,
  input  logic [3:0] spr_color,
  input  logic [3:0] backdrop_color,
  input  logic       mask_col0,
  input  logic       display_enable,
  input  logic       cram_we,
  input  logic [5:0] cram_addr,
  input  logic [7:0] cram_wd,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       de
);

  localparam logic [9:0] C_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] C_V_ACTIVE = 10'(V_ACTIVE);

  logic [11:0] r_cram [32];
  logic [7:0]  r_latch;
  logic [4:0]  r_idx;
  logic        r_act;
  logic        w_active;
  logic [4:0]  w_idx;
  logic        w_unused;

  assign w_unused = bg_color[0];
  assign w_active = (pixel_x < C_H_ACTIVE) && (pixel_y < C_V_ACTIVE);

  // A background tile only wins over a sprite when its pattern value is nonzero.
  always_comb begin
    w_idx = bg_color[5:1];
    if (!display_enable || (mask_col0 && (pixel_x < 10'd8))) begin
      w_idx = {1'b1, backdrop_color};
    end else if ((spr_color != 4'd0) && !(bg_priority && (bg_color[4:1] != 4'd0))) begin
      w_idx = {1'b1, spr_color};
    end
  end

  // Even byte is held in the latch; odd byte commits the full 12-bit entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_latch <= 8'h00;
      for (int i = 0; i < 32; i++) begin
        r_cram[i] <= 12'h000;
      end
    end else if (cram_we) begin
      if (!cram_addr[0]) begin
        r_latch <= cram_wd;
      end else begin
        r_cram[cram_addr[5:1]] <= {cram_wd[3:0], r_latch};
      end
    end
  end

  // Stage 2 reads the pre-write CRAM contents when a commit lands the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= 5'd0;
      r_act <= 1'b0;
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
      de    <= 1'b0;
    end else begin
      r_idx <= w_active ? w_idx : 5'd0;
      r_act <= w_active;
      de    <= r_act;
      if (r_act) begin
        red   <= r_cram[r_idx][3:0];
        green <= r_cram[r_idx][7:4];
        blue  <= r_cram[r_idx][11:8];
      end else begin
        red   <= 4'd0;
        green <= 4'd0;
        blue  <= 4'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vdp_color_mixer.sv
// ============================================================================
// tb_vdp_color_mixer : directed self-checking bench for vdp_color_mixer.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_vdp_color_mixer;

  logic       clk;
  logic       rst;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [5:0] bg_color;
  logic       bg_priority;
  logic [3:0] spr_color;
  logic [3:0] backdrop_color;
  logic       mask_col0;
  logic       display_enable;
  logic       cram_we;
  logic [5:0] cram_addr;
  logic [7:0] cram_wd;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       de;

  int n_checks = 0;
  int n_fail   = 0;

  vdp_color_mixer #(.H_ACTIVE(256), .V_ACTIVE(192)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .bg_color       (bg_color),
    .bg_priority    (bg_priority),
    .spr_color      (spr_color),
    .backdrop_color (backdrop_color),
    .mask_col0      (mask_col0),
    .display_enable (display_enable),
    .cram_we        (cram_we),
    .cram_addr      (cram_addr),
    .cram_wd        (cram_wd),
    .red            (red),
    .green          (green),
    .blue           (blue),
    .de             (de)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed/expected packed as {de, red, green, blue}.
  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got de/r/g/b=%h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] px(input logic d, input logic [3:0] r,
                                     input logic [3:0] g, input logic [3:0] b);
    return {d, r, g, b};
  endfunction

  // Called at #1 after a rising edge; returns #1 after the commit edge.
  task automatic cram_write(input logic [5:0] a, input logic [7:0] d);
    cram_we   = 1'b1;
    cram_addr = a;
    cram_wd   = d;
    @(posedge clk); #1;
    cram_we   = 1'b0;
  endtask

  // Drives one pixel and waits the two-clock pipeline latency.
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [5:0] bg,
                     input logic pri, input logic [3:0] spr);
    pixel_x     = x;
    pixel_y     = y;
    bg_color    = bg;
    bg_priority = pri;
    spr_color   = spr;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    pixel_x = 10'd0; pixel_y = 10'd0; bg_color = 6'd0; bg_priority = 1'b0;
    spr_color = 4'd0; backdrop_color = 4'd0; mask_col0 = 1'b0; display_enable = 1'b1;
    cram_we = 1'b0; cram_addr = 6'd0; cram_wd = 8'd0;
    #1 rst = 1'b1;
    #2 check("reset_out", {de, red, green, blue}, 13'h0000);
    @(posedge clk); #1;
    rst = 1'b0;

    // CRAM write and readback: entry 3 = 0xC5A
    cram_write(6'h06, 8'h5A);
    cram_write(6'h07, 8'hFC);
    pix(10'd20, 10'd10, 6'h06, 1'b0, 4'd0);
    check("cram_readback", {de, red, green, blue}, px(1'b1, 4'hA, 4'h5, 4'hC));

    // Priority: entry 3 = 0x111, entry 19 = 0x222
    cram_write(6'h06, 8'h11);
    cram_write(6'h07, 8'h01);
    cram_write(6'h26, 8'h22);
    cram_write(6'h27, 8'h02);
    pix(10'd20, 10'd10, 6'h06, 1'b0, 4'd3);
    check("spr_over_bg", {de, red, green, blue}, px(1'b1, 4'h2, 4'h2, 4'h2));
    pix(10'd20, 10'd10, 6'h06, 1'b1, 4'd3);
    check("bg_priority", {de, red, green, blue}, px(1'b1, 4'h1, 4'h1, 4'h1));
    pix(10'd20, 10'd10, 6'h00, 1'b1, 4'd3);
    check("bg_pri_transp", {de, red, green, blue}, px(1'b1, 4'h2, 4'h2, 4'h2));

    // Masking and backdrop: entry 21 = 0xABC
    cram_write(6'h2A, 8'hBC);
    cram_write(6'h2B, 8'h0A);
    backdrop_color = 4'd5;
    mask_col0      = 1'b1;
    pix(10'd7, 10'd10, 6'h06, 1'b0, 4'd3);
    check("mask_x7", {de, red, green, blue}, px(1'b1, 4'hC, 4'hB, 4'hA));
    pix(10'd8, 10'd10, 6'h06, 1'b0, 4'd0);
    check("mask_x8", {de, red, green, blue}, px(1'b1, 4'h1, 4'h1, 4'h1));
    mask_col0      = 1'b0;
    display_enable = 1'b0;
    pix(10'd100, 10'd10, 6'h06, 1'b0, 4'd3);
    check("disp_off", {de, red, green, blue}, px(1'b1, 4'hC, 4'hB, 4'hA));
    display_enable = 1'b1;

    // Blanking boundaries
    pix(10'd256, 10'd10, 6'h06, 1'b0, 4'd0);
    check("blank_x256", {de, red, green, blue}, 13'h0000);
    pix(10'd255, 10'd191, 6'h06, 1'b0, 4'd0);
    check("active_255_191", {de, red, green, blue}, px(1'b1, 4'h1, 4'h1, 4'h1));
    pix(10'd20, 10'd192, 6'h06, 1'b0, 4'd0);
    check("blank_y192", {de, red, green, blue}, 13'h0000);

    // Latch reuse by an odd write at a different address: entry 0 = 0x75A
    cram_write(6'h02, 8'h5A);
    cram_write(6'h01, 8'h07);
    pix(10'd20, 10'd10, 6'h00, 1'b0, 4'd0);
    check("latch_entry0", {de, red, green, blue}, px(1'b1, 4'hA, 4'h5, 4'h7));

    // Collision: commit entry 0 = 0xE34 while stage 2 reads entry 0
    cram_write(6'h00, 8'h34);
    check("pre_collision", {de, red, green, blue}, px(1'b1, 4'hA, 4'h5, 4'h7));
    cram_write(6'h01, 8'h0E);
    check("collision_old", {de, red, green, blue}, px(1'b1, 4'hA, 4'h5, 4'h7));
    @(posedge clk); #1;
    check("collision_new", {de, red, green, blue}, px(1'b1, 4'h4, 4'h3, 4'hE));

    // Async reset mid-line while streaming entry 3
    pix(10'd30, 10'd10, 6'h06, 1'b0, 4'd0);
    check("stream_pre_rst", {de, red, green, blue}, px(1'b1, 4'h1, 4'h1, 4'h1));
    #3 rst = 1'b1;
    #1 check("async_rst", {de, red, green, blue}, 13'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    pix(10'd30, 10'd10, 6'h06, 1'b0, 4'd0);
    check("cram_cleared", {de, red, green, blue}, px(1'b1, 4'h0, 4'h0, 4'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vdp_color_mixer.md
Name: vdp_color_mixer

Overview:
Downstream stage of the VDP background generator. Each clock it takes the background pixel (CRAM byte index plus priority) and the sprite pixel, and resolves priority. It applies the backdrop, the left-column mask and blanking, then looks the result up in an internal 32-entry, 12-bit Game Gear CRAM. Output is registered 4:4:4 RGB with a data-enable, feeding the video output/scaler.

Parameters:
H_ACTIVE, 256, active pixels per line; pixel_x >= H_ACTIVE is blanked.
V_ACTIVE, 192, active lines per frame; pixel_y >= V_ACTIVE is blanked.

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
pixel_x  in  10  current pixel column, aligned with bg_color/spr_color
pixel_y  in  10  current line
bg_color  in  6  background CRAM byte index; bit0 always 0, bit5 = palette half
bg_priority  in  1  background tile in front of sprites
spr_color  in  4  sprite pixel, index into upper palette; 0 = transparent
backdrop_color  in  4  backdrop index into upper palette (VDP reg 7)
mask_col0  in  1  blank leftmost 8 columns to backdrop (VDP reg 0 bit 5)
display_enable  in  1  VDP reg 1 bit 6; 0 = output backdrop everywhere active
cram_we  in  1  CPU CRAM byte write strobe, one cycle per byte
cram_addr  in  6  CRAM byte address
cram_wd  in  8  CRAM write data
red  out  4  pixel red
green  out  4  pixel green
blue  out  4  pixel blue
de  out  1  1 when red/green/blue are an active pixel

Behaviour:
- Reset (async, rst=1): red/green/blue=0, de=0, all CRAM entries=0x000, byte latch=0x00, pipeline registers=0. Effective immediately, including mid-line.
- Latency: exactly 2 clocks from pixel_x/pixel_y/bg/spr inputs to red/green/blue/de. Stage 1 registers the 5-bit palette index and an active flag. Stage 2 registers the CRAM read.
- active = (pixel_x < H_ACTIVE) && (pixel_y < V_ACTIVE).
- Index selection, stage 1, in priority order:
  - !active: index don't-care; de goes 0 and RGB goes 0 at stage 2.
  - display_enable=0, or (mask_col0=1 and pixel_x < 8): index = {1, backdrop_color}.
  - spr_color != 0 and !(bg_priority=1 and bg_color[4:1] != 0): index = {1, spr_color}.
  - Otherwise: index = bg_color[5:1]. A bg pattern value of 0 shows palette entry 0 or 16 (no backdrop substitution).
- CRAM write, Game Gear format:
  - cram_addr[0]=0: latch <= cram_wd. CRAM unchanged.
  - cram_addr[0]=1: entry[cram_addr[5:1]] <= {cram_wd[3:0], latch}. Latch unchanged.
  - An odd write with no preceding even write uses the current latch value.
- Entry decode: red = entry[3:0], green = entry[7:4], blue = entry[11:8].
- Read/write collision: a stage-2 read of the entry being committed in the same cycle returns the old value. The new value is visible from the next cycle.
- Inputs are sampled every clock. There is no stall or backpressure, and no state beyond the CRAM, the latch and the 2-stage pipeline.
- Width rules: all comparisons are unsigned 10-bit. Index is 5-bit, with no wrap concerns.

Test Plan:
- CRAM write and readback: even write addr 0x06 data 0x5A, odd write addr 0x07 data 0xFC. Then bg_color=0x06, spr_color=0, active pixel (x=20, y=10) -> 2 clocks later red=0xA, green=0x5, blue=0xC, de=1.
- Priority: entry 3=0x111, entry 19=0x222. bg_color=0x06, spr_color=3:
  - bg_priority=0 -> RGB 2,2,2.
  - bg_priority=1 -> RGB 1,1,1.
  - bg_priority=1 with bg_color=0x00 -> sprite (2,2,2).
- Masking and backdrop: backdrop_color=5, entry 21=0xABC, mask_col0=1:
  - x=7 -> RGB C,B,A.
  - x=8 -> normal bg.
  - display_enable=0 at x=100 -> C,B,A.
- Blanking: pixel_x=256 or pixel_y=192 -> de=0, RGB=0, two clocks later. pixel_x=255, y=191 -> de=1.
- Latch and collision:
  - Odd write to addr 0x01 data 0x07 with latch 0x5A -> entry 0 = 0x75A.
  - Same-cycle read of entry 0 while committing -> old value, then new value on the next pixel.
- Async reset mid-line: with de=1 streaming, assert rst between clock edges -> RGB=0 and de=0 immediately. After release, reading entry 3 returns 0x000.
